// File: rtl/uart_tx_peripheral.sv
// ---------------------------------------------------------------------------
// uart_tx_peripheral
//
// Memory-mapped 8N1 UART transmitter. Firmware writes bytes into a small FIFO
// over a simple valid/ready peripheral bus. A transmit FSM serialises them
// LSB-first onto uart_tx, back-to-back with no idle gap while data remains.
//
// Register map (byte addresses):
//   0x0 CONFIG  R/W  [15:0] divisor, [16] enable, [17] irq_en
//   0x4 DATA    W    push wdata[7:0]; dropped and overflow set when full
//   0x8 STATUS  R    [0] busy, [1] fifo_full, [2] fifo_empty,
//                    [3] overflow (cleared by this read), [15:8] fifo count
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   bus_valid  bus request strobe
//   bus_we     1 = write, 0 = read
//   bus_addr   byte address
//   bus_wdata  write data
//   bus_rdata  read data, valid while bus_ready = 1
//   bus_ready  one-cycle acknowledge, the cycle after the request
//   uart_tx    serial output, idle high
//   tx_irq     level interrupt: irq_en and transmitter fully drained
// ---------------------------------------------------------------------------
module uart_tx_peripheral #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [3:0] ADDR_CONFIG = 4'h0;
  localparam logic [3:0] ADDR_DATA   = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Configuration and status
  logic [15:0] divisor;
  logic        enable;
  logic        irq_en;
  logic        overflow;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_ok;
  logic          pop;

  // Bus decode
  logic        access;
  logic        wr_data;
  logic        rd_status;
  logic [31:0] rdata_mux;
  logic        unused_wdata;

  // Transmit FSM
  state_t      state, state_nx;
  logic [15:0] baud_cnt, baud_cnt_nx;
  logic [15:0] div_lat, div_lat_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [7:0]  shift, shift_nx;
  logic        tx_nx;
  logic        start_frame;
  logic        baud_done;
  logic        can_start;

  // A request is taken on any cycle it is not already being acknowledged, so
  // bus_ready can never be high two cycles running.
  assign access    = bus_valid & ~bus_ready;
  assign wr_data   = access & bus_we & (bus_addr == ADDR_DATA);
  assign rd_status = access & ~bus_we & (bus_addr == ADDR_STATUS);

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  assign push_ok    = wr_data & (~fifo_full | pop);

  assign unused_wdata = ^bus_wdata[31:18];

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata_mux = '0;
    case (bus_addr)
      ADDR_CONFIG: rdata_mux = {14'd0, irq_en, enable, divisor};
      ADDR_STATUS: rdata_mux = {16'd0, 8'(count), 4'd0,
                                overflow, fifo_empty, fifo_full, state != IDLE};
      default:     rdata_mux = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      divisor   <= DEFAULT_DIV;
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      bus_ready <= access;
      bus_rdata <= (access && !bus_we) ? rdata_mux : '0;
      if (access && bus_we && bus_addr == ADDR_CONFIG) begin
        divisor <= bus_wdata[15:0];
        enable  <= bus_wdata[16];
        irq_en  <= bus_wdata[17];
      end
      if (wr_data && !push_ok) begin
        overflow <= 1'b1;
      end else if (rd_status) begin
        overflow <= 1'b0;
      end
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count alone define
  // which entries are valid, so clearing the array would be wasted logic.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus_wdata[7:0];
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign baud_done = (baud_cnt == 16'd0);
  assign can_start = enable & ~fifo_empty;
  assign pop       = start_frame;

  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt;
    div_lat_nx  = div_lat;
    bit_idx_nx  = bit_idx;
    shift_nx    = shift;
    start_frame = 1'b0;
    tx_nx       = 1'b1;

    case (state)
      IDLE: begin
        start_frame = can_start;
      end
      START: begin
        if (baud_done) begin
          state_nx    = DATA;
          baud_cnt_nx = div_lat;
          bit_idx_nx  = 3'd0;
        end else begin
          baud_cnt_nx = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_nx = div_lat;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_nx = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          // Chain straight into the next start bit when more data is queued.
          start_frame = can_start;
          state_nx    = IDLE;
        end else begin
          baud_cnt_nx = baud_cnt - 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Divisor is captured per frame so CONFIG writes never stretch a frame.
    if (start_frame) begin
      state_nx    = START;
      baud_cnt_nx = divisor;
      div_lat_nx  = divisor;
      shift_nx    = mem[rd_ptr];
    end

    // uart_tx is registered from the next state to keep the pad glitch-free.
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[bit_idx_nx];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_lat  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
      tx_irq   <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      div_lat  <= div_lat_nx;
      bit_idx  <= bit_idx_nx;
      shift    <= shift_nx;
      uart_tx  <= tx_nx;
      tx_irq   <= irq_en & fifo_empty & (state == IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_peripheral
//
// Directed bench for uart_tx_peripheral. A behavioural model keeps a byte
// queue and, when a frame starts, expands the byte into the list of line
// levels it must produce (start, 8 data bits LSB-first, stop, each divisor+1
// clocks). A compare process checks uart_tx, bus_ready, tx_irq and read data
// against the model on every falling edge; literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_uart_tx_peripheral;

  localparam int unsigned DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        bus_valid;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        uart_tx;
  logic        tx_irq;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_peripheral #(
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(16'd3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_valid(bus_valid),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .uart_tx  (uart_tx),
    .tx_irq   (tx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------------ model
  bit          m_ready, m_tx, m_irq, m_busy, m_en, m_irq_en, m_ovf;
  logic [15:0] m_div;
  logic [31:0] m_rdata;
  byte unsigned m_q[$];
  bit          m_lv[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit           acc, busy0, ovf0, lvl;
    int unsigned  qn;
    byte unsigned b;
    logic [31:0]  cfg0;
    if (!rst_n) begin
      m_ready = 0; m_tx = 1; m_irq = 0; m_busy = 0;
      m_en = 0; m_irq_en = 0; m_ovf = 0; m_div = 16'd3; m_rdata = '0;
      m_q.delete();
      m_lv.delete();
    end else begin
      // Everything below is decided from values before this edge.
      acc   = bus_valid && !m_ready;
      qn    = m_q.size();
      busy0 = m_busy;
      ovf0  = m_ovf;
      cfg0  = {14'd0, m_irq_en, m_en, m_div};
      m_irq = m_irq_en && (qn == 0) && !busy0;

      // Line: a new frame begins once the previous one has fully played out.
      if (m_lv.size() == 0 && m_en && qn != 0) begin
        b = m_q.pop_front();
        for (int k = 0; k < 10; k++) begin
          lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
          repeat (int'(m_div) + 1) m_lv.push_back(lvl);
        end
      end
      if (m_lv.size() != 0) begin
        m_tx = m_lv.pop_front();
        m_busy = 1;
      end else begin
        m_tx = 1;
        m_busy = 0;
      end

      m_ready = acc;
      m_rdata = '0;
      if (acc) begin
        if (bus_we) begin
          if (bus_addr == 4'h0) begin
            m_div = bus_wdata[15:0]; m_en = bus_wdata[16]; m_irq_en = bus_wdata[17];
          end else if (bus_addr == 4'h4) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus_wdata[7:0]);
            else m_ovf = 1;
          end
        end else begin
          if (bus_addr == 4'h0) m_rdata = cfg0;
          else if (bus_addr == 4'h8) begin
            m_rdata = {16'd0, 8'(qn), 4'd0, ovf0, qn == 0, qn == DEPTH, busy0};
            m_ovf = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("uart_tx", 32'(uart_tx), 32'(m_tx));
    check("bus_ready", 32'(bus_ready), 32'(m_ready));
    check("tx_irq", 32'(tx_irq), 32'(m_irq));
    if (bus_ready === 1'b1) check("bus_rdata", bus_rdata, m_rdata);
  end

  // ------------------------------------------------------------- stimulus
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_valid = 1; bus_we = 1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_valid = 0; bus_we = 0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_valid = 1; bus_we = 0; bus_addr = a;
    @(negedge clk);
    d = bus_rdata;
    bus_valid = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Returns on the first falling edge where the line is low (cycle 0 of frame).
  task automatic wait_fall(input string name);
    int n;
    n = 0;
    while (uart_tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(uart_tx), 32'd0);
  endtask

  logic        samp [0:89];
  logic [31:0] rd;
  logic [9:0]  frame_a5;

  task automatic capture(input int n);
    samp[0] = uart_tx;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      samp[i] = uart_tx;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; bus_valid = 0; bus_we = 0; bus_addr = '0; bus_wdata = '0;

    // 1. Reset values
    repeat (2) @(negedge clk);
    check("rst uart_tx", 32'(uart_tx), 32'd1);
    check("rst bus_ready", 32'(bus_ready), 32'd0);
    check("rst tx_irq", 32'(tx_irq), 32'd0);
    rst_n = 1;
    bus_read(4'h8, rd);
    check("rst status", rd, 32'h0000_0004);
    bus_read(4'h0, rd);
    check("rst config", rd, 32'h0000_0003);

    // 2. Single byte 0xA5, 4-clock bits: start, 1,0,1,0,0,1,0,1, stop
    bus_write(4'h0, 32'h0001_0003);
    bus_write(4'h4, 32'h0000_00A5);
    wait_fall("a5 start");
    capture(45);
    frame_a5 = 10'b1_1010_0101_0;
    for (int k = 0; k < 10; k++) check($sformatf("a5 bit%0d", k), 32'(samp[4*k+1]), 32'(frame_a5[k]));
    check("a5 low-to-idle 40", 32'(samp[40]), 32'd1);

    // 3. Back-to-back 0x55, 0x0F: no idle gap between frames
    bus_write(4'h0, 32'h0000_0003);
    bus_write(4'h4, 32'h0000_0055);
    bus_write(4'h4, 32'h0000_000F);
    bus_write(4'h0, 32'h0001_0003);
    wait_fall("b2b start");
    capture(81);
    check("b2b stop1", 32'(samp[39]), 32'd1);
    check("b2b start2 no gap", 32'(samp[40]), 32'd0);
    check("b2b 0F bit0", 32'(samp[45]), 32'd1);
    check("b2b 0F bit7", 32'(samp[73]), 32'd0);
    check("b2b idle", 32'(samp[80]), 32'd1);

    // 4. Overflow with transmitter disabled
    bus_write(4'h0, 32'h0000_0000);
    for (int i = 0; i < 9; i++) bus_write(4'h4, 32'(8'h30 + i));
    bus_read(4'h8, rd);
    check("ovf status", rd, 32'h0000_080A);
    bus_read(4'h8, rd);
    check("ovf cleared", rd, 32'h0000_0802);
    bus_write(4'h0, 32'h0001_0000);   // drain at 1 clock per bit
    repeat (100) @(negedge clk);
    bus_read(4'h8, rd);
    check("drained status", rd, 32'h0000_0004);

    // 5. Mid-frame divisor change and disable
    bus_write(4'h0, 32'h0000_0003);
    bus_write(4'h4, 32'h0000_003C);
    bus_write(4'h4, 32'h0000_0096);
    bus_write(4'h4, 32'h0000_0011);
    bus_write(4'h0, 32'h0001_0003);
    wait_fall("mid start");
    bus_write(4'h0, 32'h0001_0000);   // lands in cycle 1 of frame 1
    check("mid f1 start held", 32'(uart_tx), 32'd0);
    repeat (33) @(negedge clk);
    check("mid f1 bit7 c35", 32'(uart_tx), 32'd0);
    @(negedge clk);
    check("mid f1 stop c36", 32'(uart_tx), 32'd1);
    repeat (3) @(negedge clk);
    check("mid f1 stop c39", 32'(uart_tx), 32'd1);
    @(negedge clk);
    check("mid f2 start c40", 32'(uart_tx), 32'd0);
    bus_write(4'h0, 32'h0000_0000);   // disable during frame 2
    check("mid f2 bit1 c42", 32'(uart_tx), 32'd1);
    repeat (20) @(negedge clk);
    bus_read(4'h8, rd);
    check("mid held byte", rd, 32'h0000_0100);
    apply_reset();

    // 6. Reset mid-frame, then interrupt
    bus_write(4'h0, 32'h0000_0003);
    bus_write(4'h4, 32'h0000_00C3);
    bus_write(4'h4, 32'h0000_007E);
    bus_write(4'h0, 32'h0001_0003);
    wait_fall("rst-mid start");
    repeat (13) @(negedge clk);
    check("rst-mid bit2 low", 32'(uart_tx), 32'd0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("rst-mid uart_tx", 32'(uart_tx), 32'd1);
    check("rst-mid bus_ready", 32'(bus_ready), 32'd0);
    check("rst-mid tx_irq", 32'(tx_irq), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    bus_read(4'h8, rd);
    check("rst-mid status", rd, 32'h0000_0004);

    bus_write(4'h0, 32'h0002_0000);
    repeat (3) @(negedge clk);
    check("irq idle empty", 32'(tx_irq), 32'd1);
    bus_write(4'h4, 32'h0000_0081);
    @(negedge clk);
    check("irq after push", 32'(tx_irq), 32'd0);
    bus_write(4'h0, 32'h0003_0000);
    repeat (20) @(negedge clk);
    check("irq drained", 32'(tx_irq), 32'd1);
    bus_read(4'h0, rd);
    check("irq config", rd, 32'h0003_0000);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
